// File: rtl/rf_host_sequencer_pkg.sv
// Shared types and default timing for the RF host sequencer: FSM states,
// transceiver mode encodings and the controller-clock timing constants.
package rf_host_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_WAIT,
        ST_SWITCH,
        ST_POST_WAIT,
        ST_GUARD,
        ST_SEND,
        ST_BURST_WAIT
    } state_t;

    // {M1,M0} pin encodings
    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'd0,
        MODE_WAKEUP     = 2'd1,
        MODE_POWER_SAVE = 2'd2,
        MODE_SLEEP      = 2'd3
    } mode_t;

    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_GUARD_CYCLES   = 2000;
    localparam int DEF_BURST_MAX      = 58;
    localparam int DEF_AUX_TIMEOUT    = 1000000;
    localparam int POST_IGNORE_CYCLES = 2;

    // The radio is asleep in mode 2, so nothing may be pushed to the UART;
    // mode 3 still accepts config commands.
    function automatic logic send_allowed(input mode_t m);
        return m != MODE_POWER_SAVE;
    endfunction

endpackage

// File: rtl/rf_host_sequencer_fifo.sv
// host_byte_fifo: power-of-two byte FIFO with a fall-through read port.
// Simultaneous push and pop are both honoured.
module host_byte_fifo
    import rf_host_sequencer_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
)(
    input  logic       internal_clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge internal_clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_host_sequencer.sv
// Host-side sequencer for a UART RF transceiver: switches M1/M0 modes
// around the AUX handshake and meters payload bytes out in bounded bursts.
module rf_host_sequencer
    import rf_host_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int BURST_MAX    = DEF_BURST_MAX,
    parameter int AUX_TIMEOUT  = DEF_AUX_TIMEOUT
)(
    input  logic       internal_clk,
    input  logic       rst_n,
    input  logic [1:0] mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       AUX,
    output logic       M0,
    output logic       M1,
    output logic [7:0] data_to_uart,
    output logic       TX_use,
    input  logic       TX_flag,
    output logic       busy,
    output logic       err_timeout
);

    localparam int WAIT_W  = $clog2(AUX_TIMEOUT + 1) + 1;
    localparam int GUARD_W = $clog2(GUARD_CYCLES) + 1;
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    state_t             state;
    mode_t              mode_q;
    mode_t              mode_lat;
    logic [1:0]         aux_pipe;
    logic               aux_s;
    logic               aux_low_seen;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [GUARD_W-1:0] guard_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               wait_expired;

    logic               fifo_pop;
    logic [7:0]         fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;

    host_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .push         (wr_valid),
        .wr_data      (wr_data),
        .pop          (fifo_pop),
        .rd_data      (fifo_rd_data),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    assign wr_ready     = !fifo_full;
    assign busy         = (state != ST_IDLE);
    assign {M1, M0}     = mode_q;
    assign aux_s        = aux_pipe[1];
    assign wait_expired = (wait_cnt >= WAIT_W'(AUX_TIMEOUT));
    assign fifo_pop     = (state == ST_SEND) && !fifo_empty && !TX_flag &&
                          (burst_cnt < BURST_W'(BURST_MAX));

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n)
            aux_pipe <= '0;
        else
            aux_pipe <= {aux_pipe[0], AUX};
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_SLEEP;
            mode_lat       <= MODE_SLEEP;
            mode_req_ready <= 1'b0;
            err_timeout    <= 1'b0;
            TX_use         <= 1'b0;
            data_to_uart   <= '0;
            wait_cnt       <= '0;
            guard_cnt      <= '0;
            burst_cnt      <= '0;
            aux_low_seen   <= 1'b0;
        end else begin
            mode_req_ready <= 1'b0;
            TX_use         <= fifo_pop;
            if (fifo_pop) begin
                data_to_uart <= fifo_rd_data;
                burst_cnt    <= burst_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    wait_cnt     <= '0;
                    guard_cnt    <= '0;
                    aux_low_seen <= 1'b0;
                    // Mode changes win over pending payload.
                    if (mode_req_valid) begin
                        mode_lat       <= mode_t'(mode_req);
                        mode_req_ready <= 1'b1;
                        err_timeout    <= 1'b0;
                        state          <= ST_PRE_WAIT;
                    end else if (!fifo_empty && send_allowed(mode_q)) begin
                        state <= ST_SEND;
                    end
                end

                ST_PRE_WAIT: begin
                    if (aux_s) begin
                        state <= ST_SWITCH;
                    end else if (wait_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_SWITCH: begin
                    mode_q   <= mode_lat;
                    wait_cnt <= '0;
                    state    <= ST_POST_WAIT;
                end

                // AUX drops a little after the pins move; don't trust the
                // first couple of samples.
                ST_POST_WAIT: begin
                    if (aux_s && wait_cnt >= WAIT_W'(POST_IGNORE_CYCLES)) begin
                        guard_cnt <= '0;
                        state     <= ST_GUARD;
                    end else if (wait_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_GUARD: begin
                    if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1))
                        state <= ST_IDLE;
                    else
                        guard_cnt <= guard_cnt + 1'b1;
                end

                ST_SEND: begin
                    if (fifo_empty) begin
                        burst_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (burst_cnt == BURST_W'(BURST_MAX)) begin
                        wait_cnt     <= '0;
                        aux_low_seen <= 1'b0;
                        state        <= ST_BURST_WAIT;
                    end
                end

                // Transceiver signals burst consumed by an AUX low-high cycle.
                ST_BURST_WAIT: begin
                    if (!aux_s)
                        aux_low_seen <= 1'b1;
                    if (aux_low_seen && aux_s) begin
                        burst_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (wait_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_host_sequencer.sv
// Directed bench for rf_host_sequencer: mode switch timing, payload order,
// burst metering, TX back-pressure, AUX timeout and mid-burst reset.
module tb_rf_host_sequencer;

    localparam int TO = 300;

    logic       internal_clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       AUX;
    logic       M0, M1;
    logic [7:0] data_to_uart;
    logic       TX_use;
    logic       TX_flag;
    logic       busy;
    logic       err_timeout;

    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    int         cyc_n    = 0;
    int         rx_base  = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always #5 internal_clk = ~internal_clk;

    rf_host_sequencer #(.AUX_TIMEOUT(TO)) dut (
        .internal_clk   (internal_clk),
        .rst_n          (rst_n),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .AUX            (AUX),
        .M0             (M0),
        .M1             (M1),
        .data_to_uart   (data_to_uart),
        .TX_use         (TX_use),
        .TX_flag        (TX_flag),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    always @(posedge internal_clk) cyc_n <= cyc_n + 1;

    always @(negedge internal_clk) begin
        if (TX_use) begin
            rx_q.push_back(data_to_uart);
            rx_t.push_back(cyc_n);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge internal_clk);
        #1;
    endtask

    function automatic int rx_n();
        return rx_q.size() - rx_base;
    endfunction

    task automatic push_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int b = 0;
            wr_data  = base + 8'(i);
            wr_valid = 1'b1;
            while (!wr_ready && b < 1000) begin
                cyc();
                b++;
            end
            if (b >= 1000) chk("push_ready", int'(wr_ready), 1);
            cyc();
        end
        wr_valid = 1'b0;
    endtask

    task automatic mode_switch(input logic [1:0] m);
        int b = 0;
        mode_req       = m;
        mode_req_valid = 1'b1;
        do begin
            cyc();
            b++;
        end while (!mode_req_ready && b < 5000);
        mode_req_valid = 1'b0;
        chk("mode_ack", int'(mode_req_ready), 1);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy && b < 5000) begin
            cyc();
            b++;
        end
        chk("idle", int'(busy), 0);
    endtask

    task automatic wait_rx(input int n);
        int b = 0;
        while (rx_n() < n && b < 3000) begin
            cyc();
            b++;
        end
        chk("rx_cnt", rx_n(), n);
    endtask

    task automatic check_seq(input string tag, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            chk(tag, int'(rx_q[rx_base + i]), int'(base + 8'(i)));
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        mode_req       = 2'd0;
        mode_req_valid = 1'b0;
        wr_data        = 8'h00;
        wr_valid       = 1'b0;
        AUX            = 1'b1;
        TX_flag        = 1'b0;
        repeat (3) cyc();

        // reset state
        chk("rst_mode", int'({M1, M0}), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_txuse", int'(TX_use), 0);
        chk("rst_data", int'(data_to_uart), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_wrrdy", int'(wr_ready), 1);
        chk("rst_mrdy", int'(mode_req_ready), 0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // switch to mode 0 with AUX high: pins move 2 cycles after accept,
        // 3 cycles of POST_WAIT then 2000 guard cycles
        mode_switch(2'd0);
        cyc();
        chk("sw_hold", int'({M1, M0}), 3);
        cyc();
        chk("sw_new", int'({M1, M0}), 0);
        n = 0;
        while (busy && n < 3000) begin
            cyc();
            n++;
        end
        chk("guard_len", n, 2003);

        // three bytes out back to back
        rx_base = rx_q.size();
        push_seq(3, 8'hA1);
        wait_rx(3);
        check_seq("small_data", 3, 8'hA1);
        chk("small_consec", rx_t[rx_base + 2] - rx_t[rx_base], 2);
        wait_idle();

        // TX_flag stall mid-burst
        rx_base = rx_q.size();
        fork
            push_seq(10, 8'h30);
            begin
                int b = 0;
                while (rx_n() < 3 && b < 500) begin
                    cyc();
                    b++;
                end
                TX_flag = 1'b1;
                repeat (5) begin
                    cyc();
                    chk("stall_txuse", int'(TX_use), 0);
                end
                TX_flag = 1'b0;
            end
        join
        wait_rx(10);
        check_seq("stall_data", 10, 8'h30);
        wait_idle();

        // 60 bytes: 58-byte burst, hold until AUX low->high, then 2 more
        rx_base = rx_q.size();
        fork
            push_seq(60, 8'h10);
            begin
                wait_rx(58);
                repeat (20) cyc();
                chk("burst_hold", rx_n(), 58);
                chk("burst_busy", int'(busy), 1);
                AUX = 1'b0;
                repeat (4) cyc();
                AUX = 1'b1;
                wait_rx(60);
            end
        join
        repeat (10) cyc();
        chk("burst_total", rx_n(), 60);
        check_seq("burst_data", 60, 8'h10);
        wait_idle();

        // AUX stuck low: timeout, pins unchanged
        AUX = 1'b0;
        repeat (4) cyc();
        mode_switch(2'd2);
        n = 0;
        while (!err_timeout && n < TO + 100) begin
            cyc();
            n++;
        end
        chk("to_len", n, TO + 1);
        chk("to_err", int'(err_timeout), 1);
        chk("to_mode", int'({M1, M0}), 0);
        chk("to_busy", int'(busy), 0);
        repeat (5) cyc();
        chk("to_sticky", int'(err_timeout), 1);
        AUX = 1'b1;
        repeat (4) cyc();
        mode_switch(2'd0);
        chk("err_clear", int'(err_timeout), 0);
        wait_idle();

        // mode 2 holds payload; mode 3 lets it out
        mode_switch(2'd2);
        wait_idle();
        chk("m2_pins", int'({M1, M0}), 2);
        rx_base = rx_q.size();
        push_seq(2, 8'hC0);
        repeat (40) cyc();
        chk("m2_hold", rx_n(), 0);
        chk("m2_busy", int'(busy), 0);
        mode_switch(2'd3);
        wait_rx(2);
        check_seq("m3_data", 2, 8'hC0);
        wait_idle();
        chk("m3_pins", int'({M1, M0}), 3);

        // reset mid-burst discards FIFO and stops TX_use
        rx_base = rx_q.size();
        TX_flag = 1'b1;
        push_seq(8, 8'hE0);
        repeat (2) cyc();
        TX_flag = 1'b0;
        repeat (3) cyc();
        chk("rst_pre", rx_n(), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_mode", int'({M1, M0}), 3);
        chk("mrst_txuse", int'(TX_use), 0);
        chk("mrst_data", int'(data_to_uart), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_wrrdy", int'(wr_ready), 1);
        rx_base = rx_q.size();
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (40) cyc();
        chk("mrst_quiet", rx_n(), 0);
        chk("mrst_idle", int'(busy), 0);
        push_seq(1, 8'h5A);
        wait_rx(1);
        chk("mrst_new", int'(rx_q[rx_base]), 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc_n);
        $fatal(1);
    end

endmodule
